trap_csr_unit: RTL
==================

// Module: trap_csr_unit
// PURPOSE
// - Machine-mode CSR file and trap sequencer; consumes trap_pkt_t from the trap packet generator.
// - Records trap state (mepc/mcause/mtval/mstatus) and supplies the fetch redirect target.
// - Services CSRRW/CSRRS/CSRRC accesses from the execute stage of the single-cycle core.
// PARAMETERS
// - RESET_MTVEC  32'h0000_0100  mtvec reset value (direct mode)
// - HART_ID      32'h0          mhartid read value
// - MISA_VAL     32'h4000_0100  misa read value (RV32I)
// PORTS
// - clk            in   1   core clock, rising edge
// - rst_n          in   1   asynchronous active-low reset
// - trap_pkt       in   trap_pkt_t  valid/mode/cause/pc/tval from trap packet generator
// - csr_addr       in   12  CSR address
// - csr_op         in   csr_op_t  CSR_RW / CSR_RS / CSR_RC
// - csr_en         in   1   instruction is a CSR access
// - csr_we         in   1   write intended (decoder clears it for RS/RC with rs1/uimm==0)
// - csr_wdata      in   32  rs1 value or zero-extended uimm
// - instret        in   1   an instruction retires this cycle
// - csr_rdata      out  32  old CSR value (combinational)
// - csr_illegal    out  1   unimplemented address, or write to read-only (addr[11:10]==2'b11)
// - redirect       out  1   trap_pkt.valid this cycle (combinational)
// - redirect_pc    out  32  ENTER: {mtvec[31:2],2'b00}; RETURN: mepc
// BEHAVIOUR
// - Reset (async): mstatus.MIE=0, MPIE=0, MPP=2'b11; mtvec=RESET_MTVEC & ~3; mscratch/mepc/mcause/mtval=0.
// - Reset is applied immediately mid-operation; all state updates occur on the rising edge of clk.
// - redirect, redirect_pc, csr_rdata and csr_illegal are combinational, reading pre-edge state.
// - Implemented CSRs: mstatus 0x300, misa 0x301, mtvec 0x305, mscratch 0x340, mepc 0x341,
//   mcause 0x342, mtval 0x343, mhartid 0xF14.
// - Write data: RW=wdata, RS=old|wdata, RC=old&~wdata.
// - WARL rules:
//   - mtvec[1:0] and mepc[1:0] are hardwired 0.
//   - mstatus: only MIE(3), MPIE(7) and MPP(12:11) are stored; MPP reads as 2'b11; all other bits read 0.
//   - misa writes are ignored (not illegal).
// - Unimplemented address: csr_illegal=1, rdata=0, no state change.
// - TRAP_ENTER at the edge:
//   - mepc<=pc&~3, mcause<=cause, mtval<=tval.
//   - MPIE<=MIE, MIE<=0, MPP<=2'b11.
// - TRAP_RETURN at the edge: MIE<=MPIE, MPIE<=1, MPP<=2'b11; mepc, mcause and mtval are unchanged.
// - Simultaneous trap and CSR write: the trap wins and the CSR write is suppressed
//   (the faulting instruction does not commit).
// - Back-to-back traps: each cycle's trap_pkt is applied independently; nesting overwrites mepc.
// - csr_illegal is gated by csr_en; when csr_en=0 it is 0 and writes are ignored.
// CONFIGURATION
// - TRAP_CSR_COUNTERS_EN defined: adds 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82).
//   - mcycle increments every cycle.
//   - minstret increments when instret=1 and no TRAP_ENTER occurs that cycle.
//   - A software write to either half takes priority over the increment in that cycle.
//   - Both counters wrap at 2^64 to 0; reset value is 0.
// - TRAP_CSR_COUNTERS_EN undefined: these addresses are unimplemented (csr_illegal=1).
// STRUCTURE
// - riscv_defines gains: csr_op_t, CSR_* 12-bit address constants, and MSTATUS_MIE/MPIE/MPP bit positions.
// - Sub-module trap_csr_counter64:
//   - 64-bit counter with inc, wr_lo, wr_hi and wdata inputs.
//   - Instantiated twice, only under TRAP_CSR_COUNTERS_EN.
// TESTING
// - Reset: rst_n low mid-cycle -> mtvec reads 0x100, mstatus reads 0x1800, mepc reads 0, redirect=0.
// - ECALL: MIE=1, trap_pkt ENTER cause=11, pc=0x200 -> redirect_pc=0x100;
//   next cycle mepc=0x200, mcause=11, mstatus=0x1880.
// - MRET: after the ECALL, trap_pkt RETURN -> redirect_pc=0x200; next cycle mstatus=0x1888 (MIE=1, MPIE=1).
// - CSR ops: RW mtvec 0x303 -> reads 0x300; RS mscratch 0xF0 on 0x0F -> 0xFF;
//   RC 0x0F -> 0xF0; rdata returns the old value.
// - Illegal/collision:
//   - RW to 0xF14 -> csr_illegal=1, no change.
//   - Address 0x7C0 -> illegal.
//   - RW mepc coincident with ENTER pc=0x400 -> mepc=0x400.
// - Counters (macro on):
//   - Write mcycle lo=0xFFFF_FFFF, hi=0 -> two cycles later reads hi=1, lo=0x0000_0001.
//   - instret during ENTER does not bump minstret.
//   - Macro off: 0xB00 is illegal.

Source files
------------

// File: rtl/trap_csr_unit_pkg.sv
// Shared types and constants for the machine-mode CSR file and trap sequencer.
// The optional 64-bit counters are enabled by defining TRAP_CSR_COUNTERS_EN.
package trap_csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_RW = 2'b01,
        CSR_RS = 2'b10,
        CSR_RC = 2'b11
    } csr_op_t;

    typedef enum logic {
        TRAP_ENTER  = 1'b0,
        TRAP_RETURN = 1'b1
    } trap_mode_t;

    typedef struct packed {
        logic        valid;
        trap_mode_t  mode;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } trap_pkt_t;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    // Undefined op encodings leave the register unchanged.
    function automatic logic [31:0] csr_apply_op(input csr_op_t op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        logic [31:0] result;
        case (op)
            CSR_RW:  result = wdata;
            CSR_RS:  result = old_val | wdata;
            CSR_RC:  result = old_val & ~wdata;
            default: result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/trap_csr_unit_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half overrides the increment for that cycle.
module trap_csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (wr_lo_i) begin
            count_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            count_d[63:32] = wdata_i;
        end else if (inc_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap sequencer for the single-cycle core.
// Define TRAP_CSR_COUNTERS_EN to add the mcycle/minstret counters.
module trap_csr_unit
    import trap_csr_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  trap_pkt_t   trap_pkt,
    input  logic [11:0] csr_addr,
    input  csr_op_t     csr_op,
    input  logic        csr_en,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    input  logic        instret,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic [31:0] mstatus_rd;
    logic [31:0] read_val;
    logic        implemented;
    logic        csr_write;
    logic [31:0] csr_wval;
    logic        trap_enter;

    assign trap_enter = trap_pkt.valid && (trap_pkt.mode == TRAP_ENTER);

`ifdef TRAP_CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    trap_csr_counter64 u_mcycle (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (1'b1),
        .wr_lo_i (csr_write && (csr_addr == CSR_MCYCLE)),
        .wr_hi_i (csr_write && (csr_addr == CSR_MCYCLEH)),
        .wdata_i (csr_wval),
        .count_o (mcycle)
    );

    trap_csr_counter64 u_minstret (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (instret && !trap_enter),
        .wr_lo_i (csr_write && (csr_addr == CSR_MINSTRET)),
        .wr_hi_i (csr_write && (csr_addr == CSR_MINSTRETH)),
        .wdata_i (csr_wval),
        .count_o (minstret)
    );
`else
    logic unused_instret;
    assign unused_instret = instret;
`endif

    // MPP is hardwired to machine mode, so only MIE and MPIE are actually held in flops.
    always_comb begin
        mstatus_rd                          = '0;
        mstatus_rd[MSTATUS_MIE]             = mie_q;
        mstatus_rd[MSTATUS_MPIE]            = mpie_q;
        mstatus_rd[MSTATUS_MPP_LO +: 2]     = 2'b11;
    end

    always_comb begin
        read_val    = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   read_val = mstatus_rd;
            CSR_MISA:      read_val = MISA_VAL;
            CSR_MTVEC:     read_val = mtvec_q;
            CSR_MSCRATCH:  read_val = mscratch_q;
            CSR_MEPC:      read_val = mepc_q;
            CSR_MCAUSE:    read_val = mcause_q;
            CSR_MTVAL:     read_val = mtval_q;
            CSR_MHARTID:   read_val = HART_ID;
`ifdef TRAP_CSR_COUNTERS_EN
            CSR_MCYCLE:    read_val = mcycle[31:0];
            CSR_MCYCLEH:   read_val = mcycle[63:32];
            CSR_MINSTRET:  read_val = minstret[31:0];
            CSR_MINSTRETH: read_val = minstret[63:32];
`endif
            default:       implemented = 1'b0;
        endcase
    end

    assign csr_rdata   = read_val;
    assign csr_illegal = csr_en && (!implemented || (csr_we && (csr_addr[11:10] == 2'b11)));
    assign csr_write   = csr_en && csr_we && !csr_illegal && !trap_pkt.valid;
    assign csr_wval    = csr_apply_op(csr_op, read_val, csr_wdata);

    assign redirect    = trap_pkt.valid;
    assign redirect_pc = (trap_pkt.mode == TRAP_RETURN) ? mepc_q : (mtvec_q & ~32'h3);

    // A trap in the same cycle as a CSR write wins: the faulting instruction never commits.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap_pkt.valid) begin
            if (trap_pkt.mode == TRAP_ENTER) begin
                mepc_d   = trap_pkt.pc & ~32'h3;
                mcause_d = trap_pkt.cause;
                mtval_d  = trap_pkt.tval;
                mpie_d   = mie_q;
                mie_d    = 1'b0;
            end else begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
            end
        end else if (csr_write) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = csr_wval[MSTATUS_MIE];
                    mpie_d = csr_wval[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = csr_wval & ~32'h3;
                CSR_MSCRATCH: mscratch_d = csr_wval;
                CSR_MEPC:     mepc_d     = csr_wval & ~32'h3;
                CSR_MCAUSE:   mcause_d   = csr_wval;
                CSR_MTVAL:    mtval_d    = csr_wval;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

endmodule
